// File: rtl/cp_symbol_sched.sv
// Frame scheduler: grants 64-sample preamble then data symbol bursts spaced by GAP idle cycles.
// Latency: sample out 1 cycle after its grant cycle. Backpressure: waits at gap end for source req, flags underrun.
module cp_symbol_sched #(
    parameter int DATAWIDTH = 18,
    parameter int PRE_SYMS  = 4,
    parameter int GAP       = 16
) (
    input  logic                 cp_clk,
    input  logic                 cp_rst_n,
    input  logic                 frame_start,
    input  logic [7:0]           num_data_syms,
    input  logic                 pre_req,
    input  logic [DATAWIDTH-1:0] pre_real,
    input  logic [DATAWIDTH-1:0] pre_imag,
    output logic                 pre_grant,
    input  logic                 dat_req,
    input  logic [DATAWIDTH-1:0] dat_real,
    input  logic [DATAWIDTH-1:0] dat_imag,
    output logic                 dat_grant,
    output logic [DATAWIDTH-1:0] sym_real,
    output logic [DATAWIDTH-1:0] sym_imag,
    output logic                 sym_valid,
    output logic [5:0]           sym_index,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 underrun
);
    typedef enum logic [2:0] {IDLE, PRE_BURST, PRE_GAP, DAT_BURST, DAT_GAP, DONE} state_t;

    localparam logic [5:0] GAP_LAST = 6'(GAP - 1);
    localparam logic [5:0] IDX_LAST = 6'd63;
    localparam logic [7:0] PRE_N    = 8'(PRE_SYMS);

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic [7:0]           num_q, num_d;
    logic [7:0]           pre_cnt_q, pre_cnt_d;
    logic [7:0]           dat_cnt_q, dat_cnt_d;
    logic [5:0]           idx_q, idx_d;
    logic [5:0]           gap_q, gap_d;
    logic                 und_q, und_d;
    logic [DATAWIDTH-1:0] real_q, real_d;
    logic [DATAWIDTH-1:0] imag_q, imag_d;
    logic [5:0]           sidx_q, sidx_d;
    logic                 svld_q, svld_d;
    logic                 gap_end;
    logic                 stall;

    // Gap counter saturates on its last cycle so a stalled gap simply holds there.
    assign gap_end = (gap_q == GAP_LAST);

    always_ff @(posedge cp_clk or negedge cp_rst_n) begin
        if (!cp_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE:      if (busy_q && pre_req) state_d = PRE_BURST;
            PRE_BURST: if (idx_q == IDX_LAST) state_d = PRE_GAP;
            PRE_GAP: begin
                if (gap_end) begin
                    if (pre_cnt_q < PRE_N) begin
                        if (pre_req) state_d = PRE_BURST;
                        else         stall   = 1'b1;
                    end else if (num_q != 8'd0) begin
                        if (dat_req) state_d = DAT_BURST;
                        else         stall   = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DAT_BURST: if (idx_q == IDX_LAST) state_d = DAT_GAP;
            DAT_GAP: begin
                if (gap_end) begin
                    if (dat_cnt_q < num_q) begin
                        if (dat_req) state_d = DAT_BURST;
                        else         stall   = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pre_grant  = (state_q == PRE_BURST);
        dat_grant  = (state_q == DAT_BURST);
        frame_done = (state_q == DONE);
        frame_busy = busy_q && (state_q != DONE);
    end

    always_comb begin
        busy_d    = busy_q;
        num_d     = num_q;
        pre_cnt_d = pre_cnt_q;
        dat_cnt_d = dat_cnt_q;
        idx_d     = 6'd0;
        gap_d     = 6'd0;
        und_d     = und_q | stall;
        case (state_q)
            IDLE: begin
                if (!busy_q && frame_start) begin
                    busy_d    = 1'b1;
                    num_d     = num_data_syms;
                    pre_cnt_d = 8'd0;
                    dat_cnt_d = 8'd0;
                end
            end
            PRE_BURST: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == IDX_LAST) pre_cnt_d = pre_cnt_q + 8'd1;
            end
            DAT_BURST: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == IDX_LAST) dat_cnt_d = dat_cnt_q + 8'd1;
            end
            PRE_GAP, DAT_GAP: gap_d = gap_end ? gap_q : gap_q + 6'd1;
            DONE:    busy_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        real_d = '0;
        imag_d = '0;
        sidx_d = 6'd0;
        svld_d = 1'b0;
        if (pre_grant) begin
            real_d = pre_real;
            imag_d = pre_imag;
            sidx_d = idx_q;
            svld_d = 1'b1;
        end else if (dat_grant) begin
            real_d = dat_real;
            imag_d = dat_imag;
            sidx_d = idx_q;
            svld_d = 1'b1;
        end
    end

    always_ff @(posedge cp_clk or negedge cp_rst_n) begin
        if (!cp_rst_n) begin
            busy_q    <= 1'b0;
            num_q     <= 8'd0;
            pre_cnt_q <= 8'd0;
            dat_cnt_q <= 8'd0;
            idx_q     <= 6'd0;
            gap_q     <= 6'd0;
            und_q     <= 1'b0;
            real_q    <= '0;
            imag_q    <= '0;
            sidx_q    <= 6'd0;
            svld_q    <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            num_q     <= num_d;
            pre_cnt_q <= pre_cnt_d;
            dat_cnt_q <= dat_cnt_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            und_q     <= und_d;
            real_q    <= real_d;
            imag_q    <= imag_d;
            sidx_q    <= sidx_d;
            svld_q    <= svld_d;
        end
    end

    assign sym_real  = real_q;
    assign sym_imag  = imag_q;
    assign sym_index = sidx_q;
    assign sym_valid = svld_q;
    assign underrun  = und_q;
endmodule

// File: tb/tb_cp_symbol_sched.sv
// Bench for cp_symbol_sched: random frames compared cycle by cycle against a burst-schedule model.
module tb_cp_symbol_sched;
    localparam int DW = 18;
    localparam int P  = 4;
    localparam int G  = 16;

    logic          cp_clk = 1'b0;
    logic          cp_rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [7:0]    num_data_syms = 8'd0;
    logic          pre_req = 1'b0, dat_req = 1'b0;
    logic [DW-1:0] pre_real = '0, pre_imag = '0, dat_real = '0, dat_imag = '0;
    logic          pre_grant, dat_grant, sym_valid, frame_busy, frame_done, underrun;
    logic [DW-1:0] sym_real, sym_imag;
    logic [5:0]    sym_index;

    cp_symbol_sched #(.DATAWIDTH(DW), .PRE_SYMS(P), .GAP(G)) dut (
        .cp_clk(cp_clk), .cp_rst_n(cp_rst_n), .frame_start(frame_start),
        .num_data_syms(num_data_syms), .pre_req(pre_req), .pre_real(pre_real),
        .pre_imag(pre_imag), .pre_grant(pre_grant), .dat_req(dat_req),
        .dat_real(dat_real), .dat_imag(dat_imag), .dat_grant(dat_grant),
        .sym_real(sym_real), .sym_imag(sym_imag), .sym_valid(sym_valid),
        .sym_index(sym_index), .frame_busy(frame_busy), .frame_done(frame_done),
        .underrun(underrun)
    );

    always #5 cp_clk = ~cp_clk;

    int errors = 0;
    int checks = 0;

    // Reference schedule: burst b occupies grant cycles bstart[b]..bstart[b]+63 (frame_start cycle = 0).
    int bstart[300];
    int nb, done_cyc, und_from;
    int pre_lo, pre_hi, dat_lo, dat_hi;
    int pbase, dbase;
    bit und_carry;
    int spk, spi, sdk, sdi;

    function automatic bit req_at(bit is_dat, int t);
        if (is_dat) return !(t >= dat_lo && t < dat_hi);
        return !(t >= pre_lo && t < pre_hi);
    endfunction

    function automatic void build_model(int num);
        int t, s;
        nb = P + num;
        t = 1;
        und_from = -1;
        for (int b = 0; b < nb; b++) begin
            s = t;
            while (!req_at(b >= P, s)) s++;
            if (b > 0 && s > t && und_from < 0) und_from = t + 1;
            bstart[b] = s + 1;
            t = s + 1 + 64 + G - 1;
        end
        done_cyc = t + 1;
    endfunction

    function automatic logic [DW-1:0] sval(bit is_dat, int k, int i);
        return DW'((is_dat ? dbase : pbase) + i + 256 * k);
    endfunction

    function automatic logic [47:0] exp_at(int c);
        logic pg, dg, v, und;
        logic [5:0] ix;
        logic [DW-1:0] r, im;
        pg = 0; dg = 0; v = 0; ix = '0; r = '0; im = '0;
        for (int b = 0; b < nb; b++) begin
            if (c >= bstart[b] && c < bstart[b] + 64) begin
                if (b >= P) dg = 1; else pg = 1;
            end
            if (c > bstart[b] && c <= bstart[b] + 64) begin
                v  = 1;
                ix = 6'(c - bstart[b] - 1);
                r  = sval(b >= P, (b >= P) ? b - P : b, c - bstart[b] - 1);
                im = ~r;
            end
        end
        und = und_carry || (und_from >= 0 && c >= und_from);
        return {pg, dg, v, ix, r, im, (c == done_cyc), (c >= 1 && c < done_cyc), und};
    endfunction

    function automatic logic [47:0] got_vec();
        return {pre_grant, dat_grant, sym_valid, sym_index, sym_real, sym_imag,
                frame_done, frame_busy, underrun};
    endfunction

    // Sources respond to the grants they see, driving index + 256*symbol on top of a per-frame base.
    task automatic drive_sources(int c);
        pre_req = req_at(0, c);
        dat_req = req_at(1, c);
        if (pre_grant) begin
            pre_real = sval(0, spk, spi); pre_imag = ~pre_real;
            spi++; if (spi == 64) begin spi = 0; spk++; end
        end else begin
            pre_real = DW'($urandom); pre_imag = DW'($urandom);
        end
        if (dat_grant) begin
            dat_real = sval(1, sdk, sdi); dat_imag = ~dat_real;
            sdi++; if (sdi == 64) begin sdi = 0; sdk++; end
        end else begin
            dat_real = DW'($urandom); dat_imag = DW'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge cp_clk);
        cp_rst_n = 1'b0;
        repeat (2) @(negedge cp_clk);
        cp_rst_n = 1'b1;
        und_carry = 0;
    endtask

    // Runs one frame; fs_pulse re-pulses frame_start at that cycle, abort_c asserts reset at that cycle.
    task automatic run_frame(string name, int num, int fs_pulse, int abort_c);
        logic [47:0] e, g;
        build_model(num);
        spk = 0; spi = 0; sdk = 0; sdi = 0;
        @(negedge cp_clk);
        frame_start = 1'b1;
        num_data_syms = 8'(num);
        drive_sources(0);
        for (int c = 1; c <= done_cyc + 3; c++) begin
            @(negedge cp_clk);
            frame_start = (c == fs_pulse);
            num_data_syms = 8'($urandom);
            e = exp_at(c);
            g = got_vec();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s cyc %0d: got %h expected %h", name, c, g, e);
            end
            if (c == abort_c) begin
                cp_rst_n = 1'b0;
                #1;
                checks++;
                if (got_vec() !== 48'h0) begin
                    errors++;
                    $display("FAIL %s async reset: got %h expected 0", name, got_vec());
                end
                break;
            end
            drive_sources(c);
        end
        frame_start = 1'b0;
        und_carry = und_carry || (und_from >= 0);
    endtask

    task automatic check_quiet(string name, int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge cp_clk);
            pre_req = 1'b1; dat_req = 1'b1;
            checks++;
            if ({pre_grant, dat_grant, sym_valid, frame_busy, frame_done} !== 5'b0) begin
                errors++;
                $display("FAIL %s cyc %0d: got %b expected 00000", name, c,
                         {pre_grant, dat_grant, sym_valid, frame_busy, frame_done});
            end
        end
    endtask

    task automatic clear_windows();
        pre_lo = -1; pre_hi = -1; dat_lo = -1; dat_hi = -1;
        pbase = $urandom_range(0, 2000); dbase = $urandom_range(0, 2000);
    endtask

    task automatic test_reset();
        cp_rst_n = 1'b0;
        #2;
        checks++;
        if (got_vec() !== 48'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", got_vec());
        end
        repeat (3) @(negedge cp_clk);
        cp_rst_n = 1'b1;
        und_carry = 0;
        check_quiet("idle_after_reset", 20);
    endtask

    task automatic test_nominal();
        clear_windows();
        build_model(3);
        run_frame("nominal", 3, bstart[P] + 10, -1);
    endtask

    task automatic test_zero_data();
        clear_windows();
        run_frame("zero_data", 0, -1, -1);
    endtask

    task automatic test_underrun();
        do_reset();
        clear_windows();
        dat_lo = 2 + 80 * (P + 2) - 1;
        dat_hi = dat_lo + 10;
        run_frame("underrun", 3, -1, -1);
        check_quiet("underrun_quiet", 5);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky: got %b expected 1", underrun);
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_windows();
        build_model(3);
        run_frame("reset_mid", 3, -1, bstart[P + 1] + 30);
        repeat (2) @(negedge cp_clk);
        cp_rst_n = 1'b1;
        und_carry = 0;
        check_quiet("quiet_after_abort", 150);
        clear_windows();
        run_frame("after_abort", 2, -1, -1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            clear_windows();
            pre_lo = $urandom_range(0, 400); pre_hi = pre_lo + $urandom_range(0, 40);
            dat_lo = $urandom_range(300, 700); dat_hi = dat_lo + $urandom_range(0, 40);
            run_frame("random", $urandom_range(1, 6), -1, -1);
            repeat ($urandom_range(0, 5)) @(negedge cp_clk);
        end
    endtask

    task automatic test_max_syms();
        do_reset();
        clear_windows();
        run_frame("max_syms", 255, -1, -1);
    endtask

    initial begin
        und_carry = 0;
        clear_windows();
        test_reset();
        test_nominal();
        test_zero_data();
        test_underrun();
        test_reset_mid_burst();
        test_random();
        test_max_syms();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
